data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Parametrised, handshaked data memory for the load/store stage. It accepts one byte, halfword or word request at a time on a valid/ready interface and inserts a configurable number of wait states. Loads return sign- or zero-extended data on a one-cycle response strobe. It replaces the fixed 1024-word single-cycle data memory, and adds access latency, explicit completion and unsigned loads.

## Interface
- DEPTH, 1024: memory size in 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 0: extra busy cycles per access; 0 to 15.
- ADDR_W, $clog2(DEPTH)+2: byte-address width; derived, do not override.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  reset; asynchronous, active-high.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved.
- ReqUnsigned  in  1  load zero-extends when 1; ignored for stores.
- Address  in  ADDR_W  byte address.
- WriteData  in  32  store data, right-justified.
- RespValid  out  1  one-cycle completion strobe.
- ReadData  out  32  load result; valid only while RespValid=1.
- RespFault  out  1  access rejected; valid only while RespValid=1.

## Operation
- States:
  - IDLE: ReqReady=1.
  - BUSY: lasts WAIT_CYCLES+1 cycles; a down-counter tracks it.
  - RESP: RespValid=1.
- Transitions: IDLE→BUSY on ReqValid&&ReqReady. BUSY→RESP when the counter reaches 0. RESP→IDLE unconditionally.
- Accept edge captures ReqWrite, ReqSize, ReqUnsigned, Address and WriteData. Inputs are ignored outside IDLE.
- Word index is Address[ADDR_W-1:2]. Higher address bits are not present, so addresses wrap modulo DEPTH*4.
- Memory access happens only on the BUSY→RESP edge, using the captured fields.
- Store lanes:
  - Byte: written to lane Address[1:0].
  - Half: written to lane Address[1].
  - Word: full word written.
  - Unselected bytes are unchanged.
- Loads:
  - The selected byte or half is right-justified.
  - Sign-extended from its MSB when ReqUnsigned=0, zero-extended when ReqUnsigned=1.
  - Word loads are returned unmodified.
- Stores complete with ReadData=0.
- The memory array is not reset; its contents are undefined until written.

## Timing
- Reset values: state IDLE, ReqReady=0 while Rst is high, RespValid=0, ReadData=0, RespFault=0, counter=0.
- ReqReady=1 from the first cycle after Rst deasserts.
- Latency: RespValid is high in the cycle following edge (accept edge + WAIT_CYCLES + 1).
- Throughput: one request per WAIT_CYCLES+3 cycles.
- ReadData and RespFault are registered. They return to 0 when RespValid falls.
- Reset asserted during BUSY: request dropped, no memory write, no RespValid.
- Reset asserted during RESP: RespValid clears immediately. The store has already been committed.
- A store followed by a load to the same address returns the stored value, because the store commits before the next acceptance.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A request faults if it is a half with Address[0]=1, a word with Address[1:0]≠0, or has ReqSize=11.
  - A faulting request still completes through BUSY and RESP with RespFault=1 and ReadData=0.
  - A faulting request performs no memory write.
- DMEM_ALIGN_CHECK_EN undefined:
  - RespFault is tied to 0.
  - Half accesses ignore Address[0]; word accesses ignore Address[1:0].
  - ReqSize=11 is treated as a word access.

## Test plan
All scenarios use DEPTH=1024, WAIT_CYCLES=2 unless noted.
- Word round trip: store word 0xDEADBEEF to 0x010, then load word 0x010.
  - Each RespValid is high exactly 3 edges after its accept edge; ReqReady=0 for 4 cycles.
  - Load returns ReadData=0xDEADBEEF.
- Byte lanes: store byte 0xA5 to 0x011, then load 0x011 signed, 0x011 unsigned, and word 0x010.
  - Responses: 0xFFFFFFA5, then 0x000000A5, then 0xDEADA5EF.
- Half lanes: store half 0x8001 to 0x012, then load half 0x012 signed and word 0x010.
  - Responses: 0xFFFF8001, then 0x8001A5EF.
- Misalign: load word from 0x013.
  - With DMEM_ALIGN_CHECK_EN: RespFault=1 and ReadData=0. A word store to 0x013 leaves 0x010 unchanged.
  - Without the macro: returns 0x8001A5EF.
- Reset mid-access: assert Rst one cycle into BUSY of a word store 0x12345678 to 0x020, then load 0x020.
  - No RespValid for the store.
  - ReqReady=1 in the cycle after release.
  - The load does not return 0x12345678; pre-write 0x020 with a known value.
- Hold and wrap:
  - Hold ReqValid high continuously: acceptances every 5 cycles, and inputs that change during BUSY are ignored.
  - Store 0x0000CAFE to 0x1000: it aliases 0x000, so a load from 0x000 returns 0x0000CAFE.
  - Repeat with WAIT_CYCLES=0: latency 1 edge, period 3 cycles.

Source files
------------

// File: rtl/data_memory_unit_if.sv
// Request/response bus of data_memory_unit.
// master: load/store stage issuing requests; slave: the data memory.
interface data_memory_unit_if #(
  parameter int ADDR_W = 12
) ();
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqUnsigned;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       WriteData;
  logic              RespValid;
  logic [31:0]       ReadData;
  logic              RespFault;

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqUnsigned, Address, WriteData,
    input  ReqReady, RespValid, ReadData, RespFault
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, Address, WriteData,
    output ReqReady, RespValid, ReadData, RespFault
  );
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit: handshaked byte/half/word data memory with WAIT_CYCLES
// wait states and a one-cycle response strobe.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned halves,
// misaligned words and the reserved size 11 (no write, ReadData=0).
// Without it RespFault is 0, misaligned low address bits are ignored and
// size 11 behaves as a word access.
module data_memory_unit #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = $clog2(DEPTH) + 2
) (
  input logic              Clk,
  input logic              Rst,
  data_memory_unit_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        ready_q;
  logic        resp_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  // Request fields captured on the accept edge
  logic              write_p0;
  logic [1:0]        size_p0;
  logic              unsigned_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              fault_now;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        be;
  logic [31:0]       wlane;

  // Right-justify the addressed byte/half and extend it; words pass through.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = $signed(word[{lo, 3'b000} +: 8]);
    h = $signed(lo[1] ? word[31:16] : word[15:0]);
    case (size)
      2'b00: begin
        ext = b;
        if (uns) ext[31:8] = '0;
      end
      2'b01: begin
        ext = h;
        if (uns) ext[31:16] = '0;
      end
      default: ext = $signed(word);
    endcase
    return ext;
  endfunction

  // ready_q is only ever set in IDLE, so it alone qualifies acceptance.
  assign accept = bus.ReqValid && ready_q;
  assign commit = (state == BUSY) && (cnt == 4'd0);
  assign idx    = addr_p0[ADDR_W-1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  // Flag misaligned halves/words and the reserved size encoding.
  always_comb begin
    fault_now = 1'b0;
    case (size_p0)
      2'b01:   fault_now = addr_p0[0];
      2'b10:   fault_now = |addr_p0[1:0];
      2'b11:   fault_now = 1'b1;
      default: fault_now = 1'b0;
    endcase
  end
`else
  assign fault_now = 1'b0;
`endif

  // Byte enables and lane-replicated store data for the captured request.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_p0;
    case (size_p0)
      2'b00: begin
        be    = 4'b0001 << addr_p0[1:0];
        wlane = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        be    = addr_p0[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_p0[15:0]}};
      end
      default: ;
    endcase
  end

  // Capture request fields on the accept edge; they are data, not control.
  always_ff @(posedge Clk) begin
    if (accept) begin
      write_p0    <= bus.ReqWrite;
      size_p0     <= bus.ReqSize;
      unsigned_p0 <= bus.ReqUnsigned;
      addr_p0     <= bus.Address;
      wdata_p0    <= bus.WriteData;
    end
  end

  // Store commit on the BUSY->RESP edge; an async reset forces IDLE and blocks it.
  always_ff @(posedge Clk) begin
    if (commit && write_p0 && !fault_now) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // IDLE/BUSY/RESP sequencer with registered handshake and response outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      resp_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            state   <= BUSY;
            cnt     <= 4'(WAIT_CYCLES);
            ready_q <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            resp_q  <= 1'b1;
            fault_q <= fault_now;
            rdata_q <= (!write_p0 && !fault_now)
                       ? load_extend(mem[idx], size_p0, addr_p0[1:0], unsigned_p0)
                       : 32'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          resp_q  <= 1'b0;
          fault_q <= 1'b0;
          rdata_q <= '0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ReqReady  = ready_q;
  assign bus.RespValid = resp_q;
  assign bus.ReadData  = rdata_q;
  assign bus.RespFault = fault_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: two instances (WAIT_CYCLES=2 and 0) share the
// request fields; s2 selects which one is driven and observed. Expected data
// comes from a byte-addressed array model.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        rst;
  bit          s2;
  logic        v0, v2;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        ready_o, resp_o, fault_o;
  logic [31:0] rdata_o;
  logic [31:0] last_rd;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mm [2][4096];

  always #5 clk = ~clk;

  data_memory_unit_if #(.ADDR_W(12)) if2 ();
  data_memory_unit_if #(.ADDR_W(12)) if0 ();

  assign if2.ReqValid    = v2;
  assign if2.ReqWrite    = req_write;
  assign if2.ReqSize     = req_size;
  assign if2.ReqUnsigned = req_uns;
  assign if2.Address     = req_addr[11:0];
  assign if2.WriteData   = req_wdata;
  assign if0.ReqValid    = v0;
  assign if0.ReqWrite    = req_write;
  assign if0.ReqSize     = req_size;
  assign if0.ReqUnsigned = req_uns;
  assign if0.Address     = req_addr[11:0];
  assign if0.WriteData   = req_wdata;

  assign ready_o = s2 ? if2.ReqReady  : if0.ReqReady;
  assign resp_o  = s2 ? if2.RespValid : if0.RespValid;
  assign fault_o = s2 ? if2.RespFault : if0.RespFault;
  assign rdata_o = s2 ? if2.ReadData  : if0.ReadData;

  data_memory_unit #(.DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
    .Clk(clk), .Rst(rst), .bus(if2.slave)
  );
  data_memory_unit #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
    .Clk(clk), .Rst(rst), .bus(if0.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic x);
    if (s2) v2 = x;
    else    v0 = x;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_fault(input logic [31:0] a, input logic [1:0] sz);
    bit bad;
    bad = (sz == 2'b11) || ((int'(a[11:0]) % nbytes(sz)) != 0);
`ifndef DMEM_ALIGN_CHECK_EN
    bad = 1'b0;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] m_load(input bit d, input logic [31:0] a,
                                         input logic [1:0] sz, input bit u);
    int n, ai, base;
    longint v;
    n = nbytes(sz);
    ai = int'(a[11:0]);
    base = ai - (ai % n);
    v = 0;
    if (m_fault(a, sz)) return 32'd0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mm[d][base + i]);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic m_store(input bit d, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd);
    int n, ai, base;
    n = nbytes(sz);
    ai = int'(a[11:0]);
    base = ai - (ai % n);
    if (m_fault(a, sz)) return;
    for (int i = 0; i < n; i++) mm[d][base + i] = 8'(wd >> (8 * i));
  endtask

  // One complete transaction with latency, busy-time and response checks.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] exp_d, got_d;
    logic        exp_f, got_f;
    int          t, edges, low, lat;
    lat = s2 ? 3 : 1;
    @(negedge clk);
    req_write = w; req_size = sz; req_uns = u; req_addr = a; req_wdata = wd;
    set_valid(1'b1);
    t = 0;
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) begin
      check({tag, " ready timeout"}, 32'd0, 32'd1);
      set_valid(1'b0);
      return;
    end
    exp_f = m_fault(a, sz);
    exp_d = w ? 32'd0 : m_load(s2, a, sz, u);
    if (w) m_store(s2, a, sz, wd);
    @(posedge clk);
    #1 set_valid(1'b0);
    edges = 0;
    low = 0;
    @(negedge clk);
    while (!resp_o && edges < 40) begin
      if (!ready_o) low++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!ready_o) low++;
    got_d = rdata_o;
    got_f = fault_o;
    check({tag, " latency"}, 32'(edges), 32'(lat));
    check({tag, " ready low cycles"}, 32'(low), 32'(lat + 1));
    check({tag, " rdata"}, got_d, exp_d);
    check({tag, " fault"}, 32'(got_f), 32'(exp_f));
    @(posedge clk);
    @(negedge clk);
    check({tag, " resp drops"}, 32'(resp_o), 32'd0);
    check({tag, " rdata clears"}, rdata_o, 32'd0);
    check({tag, " fault clears"}, 32'(fault_o), 32'd0);
    check({tag, " ready back"}, 32'(ready_o), 32'd1);
    last_rd = got_d;
  endtask

  // Hold ReqValid high across three word stores, scrambling inputs while busy.
  task automatic hold_run(input logic [31:0] base);
    int          i, guard;
    longint      t, prev;
    logic [31:0] data [3];
    logic [31:0] per;
    per = s2 ? 32'd5 : 32'd3;
    for (int k = 0; k < 3; k++) data[k] = $urandom;
    i = 0; guard = 0; prev = 0;
    while (i < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (ready_o) begin
        if (i == 3) begin
          set_valid(1'b0);
          i = 4;
        end else begin
          req_write = 1'b1; req_size = 2'b10; req_uns = 1'b0;
          req_addr = base + 32'(4 * i); req_wdata = data[i];
          set_valid(1'b1);
          m_store(s2, req_addr, 2'b10, data[i]);
          @(posedge clk);
          t = $time;
          if (i > 0) check("hold period", 32'((t - prev) / 10), per);
          prev = t;
          #1;
          req_wdata = ~data[i];
          req_size  = 2'b00;
          i++;
        end
      end
    end
    if (i < 4) check("hold timeout", 32'd0, 32'd1);
    set_valid(1'b0);
    for (int k = 0; k < 3; k++) begin
      do_req(1'b0, 2'b10, 1'b0, base + 32'(4 * k), 32'd0, "hold load");
      check("hold data", last_rd, data[k]);
    end
  endtask

  initial begin
    int t;
    logic [31:0] a;
    rst = 1'b1; v0 = 1'b0; v2 = 1'b0; s2 = 1'b1;
    req_write = 1'b0; req_size = 2'b00; req_uns = 1'b0; req_addr = '0; req_wdata = '0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      s2 = (k == 1);
      #1;
      check("reset ready", 32'(ready_o), 32'd0);
      check("reset resp", 32'(resp_o), 32'd0);
      check("reset rdata", rdata_o, 32'd0);
      check("reset fault", 32'(fault_o), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      s2 = (k == 1);
      #1 check("ready after reset", 32'(ready_o), 32'd1);
    end

    // Prefill words 0x000..0x03C of both instances
    for (int k = 0; k < 2; k++) begin
      s2 = (k == 1);
      for (int j = 0; j < 16; j++) do_req(1'b1, 2'b10, 1'b0, 32'(4 * j), $urandom, "prefill");
    end

    s2 = 1'b1;
    do_req(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, "word store");
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, "word load");
    check("word value", last_rd, 32'hDEADBEEF);

    do_req(1'b1, 2'b00, 1'b0, 32'h011, 32'h000000A5, "byte store");
    do_req(1'b0, 2'b00, 1'b0, 32'h011, 32'd0, "byte load s");
    check("byte signed", last_rd, 32'hFFFFFFA5);
    do_req(1'b0, 2'b00, 1'b1, 32'h011, 32'd0, "byte load u");
    check("byte unsigned", last_rd, 32'h000000A5);
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, "byte word");
    check("byte word", last_rd, 32'hDEADA5EF);

    do_req(1'b1, 2'b01, 1'b0, 32'h012, 32'h00008001, "half store");
    do_req(1'b0, 2'b01, 1'b0, 32'h012, 32'd0, "half load s");
    check("half signed", last_rd, 32'hFFFF8001);
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, "half word");
    check("half word", last_rd, 32'h8001A5EF);

    do_req(1'b0, 2'b10, 1'b0, 32'h013, 32'd0, "misalign load");
`ifdef DMEM_ALIGN_CHECK_EN
    check("misalign load data", last_rd, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h013, 32'h11223344, "misalign store");
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, "misalign after");
    check("misalign no write", last_rd, 32'h8001A5EF);
`else
    check("misalign load data", last_rd, 32'h8001A5EF);
`endif

    // Reset one cycle into BUSY of a store
    do_req(1'b1, 2'b10, 1'b0, 32'h020, 32'hA5A55A5A, "prewrite");
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h020; req_wdata = 32'h12345678;
    set_valid(1'b1);
    t = 0;
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst busy ready seen", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1 set_valid(1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst busy no resp", 32'(resp_o), 32'd0);
    end
    check("rst busy ready low", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst release no resp", 32'(resp_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst release ready", 32'(ready_o), 32'd1);
    check("rst release still no resp", 32'(resp_o), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h020, 32'd0, "rst load");
    check("rst dropped store", last_rd, 32'hA5A55A5A);

    // Reset while the response strobe is high
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h030; req_wdata = 32'h0BADF00D;
    set_valid(1'b1);
    t = 0;
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    m_store(s2, 32'h030, 2'b10, 32'h0BADF00D);
    @(posedge clk);
    #1 set_valid(1'b0);
    t = 0;
    @(negedge clk);
    while (!resp_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("resp before reset", 32'(resp_o), 32'd1);
    #1 rst = 1'b1;
    #1 check("resp cleared by reset", 32'(resp_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready after resp reset", 32'(ready_o), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h030, 32'd0, "committed load");
    check("committed store", last_rd, 32'h0BADF00D);

    // Wrap and hold on both instances
    for (int k = 0; k < 2; k++) begin
      s2 = (k == 0);
      do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h0000CAFE, "wrap store");
      do_req(1'b0, 2'b10, 1'b0, 32'h000, 32'd0, "wrap load");
      check("wrap value", last_rd, 32'h0000CAFE);
      hold_run(32'h100);
    end

    // WAIT_CYCLES=0 word round trip
    s2 = 1'b0;
    do_req(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, "w0 word store");
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, "w0 word load");
    check("w0 word value", last_rd, 32'hDEADBEEF);

    // Random traffic in the prefilled region, with and without alias bit
    for (int k = 0; k < 2; k++) begin
      s2 = (k == 1);
      for (int j = 0; j < 30; j++) begin
        a = 32'($urandom_range(0, 63)) + ($urandom_range(0, 1) ? 32'h1000 : 32'h0);
        do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, $urandom, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
